cp0_exc_ctrl: RTL and testbench

Coprocessor-0 exception and interrupt controller for the pipelined MIPS CPU. It sits at the M stage, holds the SR, Cause, EPC and PRId registers, and decides each cycle whether the pipeline must be redirected to the handler. It drives the `req` line that forces the PC to the handler entry, and it supplies EPC for `eret`.

---
 rtl/cp0_exc_ctrl.sv | 119 +++++++++++
 tb/tb_cp0_exc_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// ============================================================================
// Module  : cp0_exc_ctrl
// Brief   : CP0 exception/interrupt controller (SR, Cause, EPC, PRId) at M stage
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_exc_ctrl #(
    parameter logic [31:0] PRID_VAL = 32'h2023_0707
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] Din,
    input  logic        WE,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] CP0Out,
    output logic [31:0] EPCOut
);

    localparam logic [4:0] c_REG_SR    = 5'd12;
    localparam logic [4:0] c_REG_CAUSE = 5'd13;
    localparam logic [4:0] c_REG_EPC   = 5'd14;
    localparam logic [4:0] c_REG_PRID  = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [29:0] epc_q, epc_d;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic [29:0] w_victim_word;
    logic        unused_vpc;

    assign w_int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign w_exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
    // Reset gates the request so a mid-handler reset never redirects the PC.
    assign w_req     = (w_int_req | w_exc_req) & ~reset;
    assign Req       = w_req;

    // Word address of the victim; a delay-slot victim restarts at its branch.
    assign w_victim_word = VPC[31:2] - (BDIn ? 30'd1 : 30'd0);
    assign unused_vpc    = ^VPC[1:0];

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ip_d      = HWInt;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (w_req) begin
            exl_d     = 1'b1;
            exccode_d = w_int_req ? 5'd0 : ExcCodeIn;
            bd_d      = BDIn;
            epc_d     = w_victim_word;
        end else begin
            if (WE && (A2 == c_REG_SR)) begin
                im_d  = Din[15:10];
                exl_d = Din[1];
                ie_d  = Din[0];
            end
            if (WE && (A2 == c_REG_EPC)) begin
                epc_d = Din[31:2];
            end
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 30'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        CP0Out = 32'd0;
        case (A1)
            c_REG_SR:    CP0Out = {16'd0, im_q, 8'd0, exl_q, ie_q};
            c_REG_CAUSE: CP0Out = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'b00};
            c_REG_EPC:   CP0Out = {epc_q, 2'b00};
            c_REG_PRID:  CP0Out = PRID_VAL;
            default:     CP0Out = 32'd0;
        endcase
    end

    assign EPCOut = {epc_q, 2'b00};

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
// ============================================================================
// Module  : tb_cp0_exc_ctrl
// Brief   : Directed self-checking bench for cp0_exc_ctrl
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_exc_ctrl;

    localparam logic [31:0] c_PRID = 32'h2023_0707;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] Din;
    logic        WE;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] CP0Out;
    logic [31:0] EPCOut;

    int n_vec;
    int n_err;

    cp0_exc_ctrl #(.PRID_VAL(c_PRID)) dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (A1),
        .A2        (A2),
        .Din       (Din),
        .WE        (WE),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .Req       (Req),
        .CP0Out    (CP0Out),
        .EPCOut    (EPCOut)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        A1 = addr;
        #1;
        chk(tag, CP0Out, exp);
    endtask

    task automatic req_is(input string tag, input logic exp);
        #1;
        chk(tag, {31'd0, Req}, {31'd0, exp});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1; A1 = 5'd0; A2 = 5'd0; Din = 32'd0; WE = 1'b0;
        VPC = 32'd0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // 1: reset state
        req_is("rst_req", 1'b0);
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, c_PRID);
        rd("rst_other", 5'd3, 32'h0);
        chk("rst_epcout", EPCOut, 32'h0);

        // 2: interrupt
        WE = 1'b1; A2 = 5'd12; Din = 32'h0000_FC01;
        tick();
        WE = 1'b0;
        rd("sr_wr", 5'd12, 32'h0000_FC01);
        HWInt = 6'b000100; VPC = 32'h0000_3010; BDIn = 1'b0;
        req_is("int_req", 1'b1);
        tick();
        chk("int_epcout", EPCOut, 32'h0000_3010);
        rd("int_cause", 5'd13, 32'h0000_1000);
        rd("int_sr", 5'd12, 32'h0000_FC03);
        req_is("int_req_drop", 1'b0);
        HWInt = 6'd0;
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_FC01);

        // 3: RI in a delay slot
        ExcCodeIn = 5'd10; VPC = 32'h0000_3024; BDIn = 1'b1;
        req_is("ri_req", 1'b1);
        tick();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        chk("ri_epcout", EPCOut, 32'h0000_3020);
        rd("ri_cause", 5'd13, 32'h8000_0028);
        rd("ri_sr", 5'd12, 32'h0000_FC03);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;

        // 4: interrupt beats exception, then nested exception ignored
        ExcCodeIn = 5'd4; HWInt = 6'b000001; VPC = 32'h0000_3040;
        req_is("both_req", 1'b1);
        tick();
        rd("both_cause", 5'd13, 32'h0000_0400);
        chk("both_epc", EPCOut, 32'h0000_3040);
        HWInt = 6'd0; ExcCodeIn = 5'd12; VPC = 32'h0000_3044;
        req_is("nest_req", 1'b0);
        tick();
        ExcCodeIn = 5'd0;
        rd("nest_cause", 5'd13, 32'h0000_0000);
        chk("nest_epc", EPCOut, 32'h0000_3040);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;

        // 5: mtc0 EPC dropped under Req, honoured otherwise
        ExcCodeIn = 5'd8; VPC = 32'h0000_3050;
        WE = 1'b1; A2 = 5'd14; Din = 32'h0000_3ABF;
        req_is("sys_req", 1'b1);
        tick();
        WE = 1'b0; ExcCodeIn = 5'd0;
        chk("sys_epc", EPCOut, 32'h0000_3050);
        rd("sys_cause", 5'd13, 32'h0000_0020);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        WE = 1'b1; A2 = 5'd14; Din = 32'h0000_3ABF;
        tick();
        chk("epc_wr", EPCOut, 32'h0000_3ABC);
        A2 = 5'd13; Din = 32'hFFFF_FFFF;
        tick();
        rd("cause_ro", 5'd13, 32'h0000_0020);
        A2 = 5'd12; Din = 32'h0000_FC03; EXLClr = 1'b1;
        tick();
        WE = 1'b0; EXLClr = 1'b0;
        rd("exlclr_over", 5'd12, 32'h0000_FC01);

        // 6: eret with pending interrupt, then reset mid-request
        ExcCodeIn = 5'd8; VPC = 32'h0000_3060;
        tick();
        ExcCodeIn = 5'd0;
        rd("pre6_sr", 5'd12, 32'h0000_FC03);
        HWInt = 6'b000010; EXLClr = 1'b1;
        req_is("eret_req0", 1'b0);
        tick();
        EXLClr = 1'b0;
        req_is("eret_req1", 1'b1);
        reset = 1'b1;
        req_is("rst_gate", 1'b0);
        tick();
        reset = 1'b0; HWInt = 6'd0;
        req_is("post_rst_req", 1'b0);
        rd("post_rst_sr", 5'd12, 32'h0);
        rd("post_rst_cause", 5'd13, 32'h0);
        chk("post_rst_epc", EPCOut, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
